// File: rtl/rr_mux4_if.sv
// Stream bundle for the 4-to-1 round-robin mux: four producer channels in,
// one registered tagged channel out, plus the accepted-beat counter.
interface rr_mux4_if #(
    parameter int WIDTH = 8
);
    logic [3:0]         in_valid;
    logic [4*WIDTH-1:0] in_data;
    logic [3:0]         in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [1:0]         out_sel;
    logic               out_ready;
    logic [15:0]        beat_cnt;

    // master is the mux itself; slave is the surrounding producers/consumer
    modport master (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel, beat_cnt
    );

    modport slave (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel, beat_cnt
    );
endinterface

// File: rtl/rr_mux4.sv
// Four-to-one round-robin stream multiplexer with a single registered output
// stage, source tag on every beat and a wrapping accepted-beat counter.
module rr_mux4 #(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    rr_mux4_if.master bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [15:0]      cnt_q, cnt_d;

    logic             load_en;
    logic             grant_vld;
    logic [1:0]       grant_idx;
    logic             xfer;

    // Scan from ptr+3 down to ptr so the last hit is the first in search order.
    always_comb begin
        logic [1:0] idx;
        // NOTE: every comb output gets a default first so no path can infer a latch.
        idx       = ptr_q;
        grant_vld = 1'b0;
        grant_idx = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr_q + 2'(i);
            if (bus.in_valid[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
    end

    assign load_en = (state_q == EMPTY) | bus.out_ready;
    assign xfer    = load_en & grant_vld;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: drain-and-reload happens on the same edge, so no bubble.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (load_en) begin
            state_d = grant_vld ? FULL : EMPTY;
        end
        if (xfer) begin
            data_d = bus.in_data[int'(grant_idx)*WIDTH +: WIDTH];
            sel_d  = grant_idx;
            ptr_d  = grant_idx + 2'd1;
            cnt_d  = cnt_q + 16'd1;
        end
    end

    // Ready is also held low while reset is asserted, independent of inputs.
    always_comb begin
        bus.in_ready  = '0;
        if (xfer && rst_n) begin
            bus.in_ready[grant_idx] = 1'b1;
        end
        bus.out_valid = (state_q == FULL);
        bus.out_data  = data_q;
        bus.out_sel   = sel_q;
        bus.beat_cnt  = cnt_q;
    end

endmodule

// File: tb/tb_rr_mux4.sv
// Directed self-checking bench for rr_mux4: reset, single beat, fairness,
// backpressure, pointer skip, counter wrap and mid-stream async reset.
module tb_rr_mux4;

    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rr_mux4_if #(.WIDTH(WIDTH)) bus ();

    rr_mux4 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
            $error("check %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and land 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
        bus.in_data = {d3, d2, d1, d0};
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] d,
                             input logic [1:0] s, input logic [15:0] c);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
        check({tag, "_data"},  32'(bus.out_data),  32'(d));
        check({tag, "_sel"},   32'(bus.out_sel),   32'(s));
        check({tag, "_cnt"},   32'(bus.beat_cnt),  32'(c));
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Reset with arbitrary inputs applied
        rst_n         = 1'b0;
        bus.in_valid  = 4'b1111;
        bus.in_data   = $urandom;
        bus.out_ready = 1'b1;
        #2;
        check("rst_ready", 32'(bus.in_ready), 32'h0);
        check_out("rst", 1'b0, 8'h00, 2'd0, 16'd0);
        step();
        bus.in_valid = 4'b0110;
        bus.out_ready = 1'b0;
        #1;
        check("rst_ready2", 32'(bus.in_ready), 32'h0);
        check_out("rst2", 1'b0, 8'h00, 2'd0, 16'd0);

        // Release with no valid inputs: outputs stay clear
        bus.in_valid  = 4'b0000;
        bus.out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        step();
        check_out("idle", 1'b0, 8'h00, 2'd0, 16'd0);

        // Single beat on channel 2
        set_data(8'h00, 8'h00, 8'hA5, 8'h00);
        bus.in_valid = 4'b0100;
        #1;
        check("single_ready", 32'(bus.in_ready), 32'b0100);
        step();
        bus.in_valid = 4'b0000;
        #1;
        check_out("single", 1'b1, 8'hA5, 2'd2, 16'd1);

        // ptr must now be 3: all valid grants channel 3 first
        set_data(8'h10, 8'h11, 8'h12, 8'h13);
        bus.in_valid = 4'b1111;
        #1;
        check("ptr3_ready", 32'(bus.in_ready), 32'b1000);
        step();
        check_out("ptr3", 1'b1, 8'h13, 2'd3, 16'd2);

        // Fairness: continuous valid on all channels, out_ready high
        for (int k = 0; k < 8; k++) begin
            check("fair_ready", 32'(bus.in_ready), 32'(4'b0001 << (k % 4)));
            step();
            check_out("fair", 1'b1, 8'(8'h10 + (k % 4)), 2'(k % 4), 16'(3 + k));
        end

        // Backpressure: hold channel 1 beat 0x3C while out_ready is low
        set_data(8'h10, 8'h3C, 8'h12, 8'h13);
        bus.in_valid = 4'b0010;
        #1;
        check("bp_load_ready", 32'(bus.in_ready), 32'b0010);
        step();
        check_out("bp_load", 1'b1, 8'h3C, 2'd1, 16'd11);
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_ready", 32'(bus.in_ready), 32'h0);
            set_data(8'h10, 8'hC3, 8'h12, 8'h13);
            step();
            check_out("bp_hold", 1'b1, 8'h3C, 2'd1, 16'd11);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(bus.in_ready), 32'b0100);
        step();
        check_out("bp_release", 1'b1, 8'h12, 2'd2, 16'd12);

        // Pointer skip: grant channel 0 (ptr -> 1), idle, then 4'b1001
        set_data(8'h20, 8'h21, 8'h22, 8'h23);
        bus.in_valid = 4'b0001;
        step();
        check_out("skip_ch0", 1'b1, 8'h20, 2'd0, 16'd13);
        bus.in_valid = 4'b0000;
        step();
        check_out("skip_idle", 1'b0, 8'h20, 2'd0, 16'd13);
        step();
        bus.in_valid = 4'b1001;
        #1;
        check("skip_ready3", 32'(bus.in_ready), 32'b1000);
        step();
        check_out("skip_ch3", 1'b1, 8'h23, 2'd3, 16'd14);
        check("skip_ready0", 32'(bus.in_ready), 32'b0001);
        step();
        check_out("skip_ch0b", 1'b1, 8'h20, 2'd0, 16'd15);

        // Counter wrap: stream full-rate up to 0xFFFF, then one more beat
        set_data(8'h30, 8'h31, 8'h32, 8'h33);
        bus.in_valid = 4'b1111;
        for (int k = 0; k < 16'hFFFF - 15; k++) begin
            @(posedge clk);
        end
        #1;
        check("wrap_max", 32'(bus.beat_cnt), 32'hFFFF);
        check("wrap_valid", 32'(bus.out_valid), 32'h1);
        step();
        check("wrap_zero", 32'(bus.beat_cnt), 32'h0);

        // Async reset mid-handshake: outputs clear before the next edge
        bus.in_valid = 4'b0100;
        #1;
        check("mid_ready", 32'(bus.in_ready), 32'b0100);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(bus.in_ready), 32'h0);
        check_out("mid_rst", 1'b0, 8'h00, 2'd0, 16'd0);
        bus.in_valid = 4'b0000;
        step();
        rst_n = 1'b1;
        step();
        check_out("post_rst", 1'b0, 8'h00, 2'd0, 16'd0);

        // ptr back at 0: channels 2 and 3 valid grants channel 2
        bus.in_valid = 4'b1100;
        #1;
        check("post_rst_ready", 32'(bus.in_ready), 32'b0100);
        step();
        check_out("post_rst_beat", 1'b1, 8'h32, 2'd2, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_mux4.md
# rr_mux4

Four-to-one round-robin stream multiplexer. It is the collecting end of the 1-to-4 demultiplexer path: four independent valid/ready producers share one registered output channel. Each beat carries a 2-bit `out_sel` tag that names its source channel, so a downstream demux can route it back. Arbitration is fair round-robin, throughput is one beat per cycle, and the output holds stable under backpressure.

## Interface
- `WIDTH`, default 8: data width per channel.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 4: per-channel valid; bit k belongs to channel k.
- `in_data` input 4*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
- `in_ready` output 4: per-channel ready; at most one bit high per cycle.
- `out_valid` output 1: output register holds a beat.
- `out_data` output WIDTH: registered data of the held beat.
- `out_sel` output 2: source channel index of the held beat.
- `out_ready` input 1: downstream accepts the beat this cycle.
- `beat_cnt` output 16: count of beats accepted from the inputs.

## Operation
- State: output register (`out_valid`, `out_data`, `out_sel`), 2-bit round-robin pointer `ptr`, 16-bit `beat_cnt`.
- Output register behaves as a two-state FSM:
  - EMPTY: `out_valid`=0.
  - FULL: `out_valid`=1.
- `load_en = ~out_valid | out_ready`, computed combinationally.
- Grant search order: `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, all mod 4. The grant `g` is the first channel in that order with `in_valid` high.
- `in_ready[g] = load_en`. All other `in_ready` bits are 0. All bits are 0 when no channel is valid.
- A transfer on channel g happens when `in_valid[g] & in_ready[g]`. On the next edge:
  - `out_data` <= channel g data.
  - `out_sel` <= g.
  - `out_valid` <= 1.
  - `ptr` <= (g+1) mod 4.
  - `beat_cnt` <= `beat_cnt`+1, wrapping from 0xFFFF to 0.
- `load_en` high with no valid input: `out_valid` <= 0. `out_data`, `out_sel` and `ptr` are unchanged.
- `load_en` low (FULL and `out_ready`=0): all state holds, and `out_data`/`out_sel` stay bit-stable.
- When `out_ready` and a new grant occur in the same cycle, the output drains and reloads on the same edge with no bubble.
- `in_valid` dropping without a handshake is tolerated. No state changes from it.
- `ptr` only advances on a transfer, never on idle cycles.

## Timing
- Reset, asynchronous assert:
  - `out_valid`=0, `out_data`=0, `out_sel`=0, `ptr`=0, `beat_cnt`=0.
  - `in_ready`=0 while `rst_n` is low.
- Reset release: first grant can occur in the first cycle with `rst_n` high.
- Latency: an input beat accepted at edge N is visible on the output right after edge N. That is one cycle, registered.
- Throughput: one beat per cycle when `out_ready` is held high.
- Combinational paths: `in_ready` depends on `in_valid`, `out_valid`, `out_ready` and `ptr`. There is no combinational path from `in_data` to any output.
- Reset mid-stream: the held beat is discarded. The pending handshake is not counted, and `ptr` returns to 0.

## Test plan
- Reset: drive random inputs with `rst_n`=0 -> all outputs 0, `in_ready`=4'b0000. Deassert reset -> outputs stay 0 until the first valid.
- Single beat: `in_valid`=4'b0100, channel 2 = 0xA5, `out_ready`=1 -> `in_ready`=4'b0100. Next cycle `out_valid`=1, `out_data`=0xA5, `out_sel`=2, `beat_cnt`=1, `ptr`=3.
- Fairness: all four channels continuously valid with data 0x10+k, `out_ready`=1, 8 cycles -> `out_sel` sequence 0,1,2,3,0,1,2,3. No bubbles, `beat_cnt`=8.
- Backpressure: FULL with channel 1 = 0x3C, `out_ready`=0 for 3 cycles, all inputs valid -> `out_data`=0x3C and `out_sel`=1 stable, `in_ready`=0. `out_ready`=1 -> next grant is channel 2 in that cycle.
- Pointer skip: after a grant to channel 0 (`ptr`=1), `in_valid`=4'b1001 -> channel 3 is granted, then channel 0. Idle cycles in between leave `ptr` unchanged.
- Counter wrap and async reset: preload 0xFFFF beats -> the next beat gives `beat_cnt`=0. Assert `rst_n` low mid-handshake -> outputs clear immediately, and the beat is not reissued after release.
